out_channel: RTL and testbench



---
 rtl/out_channel.sv | 146 ++++++++++++++
 tb/tb_out_channel.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_channel.sv
// rtl/out_channel.sv - Output FIFO stage behind the Zero executor: buffers `out` words,
// streams them to the drain port and checks them against a loaded expected-value table.
module out_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 2000,
  parameter int NExpect            = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            outValid,
  input  logic [MemoryElementWidth-1:0]   outData,
  output logic                            outReady,
  input  logic                            execFinished,
  output logic                            drainValid,
  output logic [MemoryElementWidth-1:0]   drainData,
  input  logic                            drainReady,
  input  logic                            expectWe,
  input  logic [$clog2(NExpect)-1:0]      expectAddr,
  input  logic [MemoryElementWidth-1:0]   expectData,
  input  logic [$clog2(NExpect+1)-1:0]    expectCount,
  output logic [$clog2(NOut+1)-1:0]       wordsOut,
  output logic                            finished,
  output logic                            success
);

  localparam int PW = $clog2(NOut);
  localparam int CW = $clog2(NOut+1);
  localparam int AW = $clog2(NExpect);
  localparam int KW = $clog2(NExpect+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic                          r_rst_meta;
  logic                          r_rst_n;
  logic [1:0]                    r_state;
  logic [1:0]                    w_state_next;
  logic [MemoryElementWidth-1:0] r_mem [NOut];
  logic [MemoryElementWidth-1:0] r_expect [NExpect];
  logic [PW-1:0]                 r_wr_ptr;
  logic [PW-1:0]                 r_rd_ptr;
  logic [PW-1:0]                 w_rd_ptr_next;
  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 w_count_next;
  logic [KW-1:0]                 r_k;
  logic [KW-1:0]                 r_exp_count;
  logic                          r_mismatch;
  logic                          r_out_ready;
  logic                          r_drain_valid;
  logic [MemoryElementWidth-1:0] r_drain_data;
  logic                          r_finished;
  logic                          r_success;
  logic [MemoryElementWidth-1:0] w_head_data;
  logic                          w_wr;
  logic                          w_rd;
  logic                          w_k_in_range;
  logic                          w_check_bad;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NOut - 1)) ? '0 : p + 1'b1;
  endfunction

  // Assertion is immediate; release is aligned to clock through two flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  assign w_wr          = outValid && r_out_ready;
  assign w_rd          = r_drain_valid && drainReady;
  assign w_count_next  = r_count + CW'(w_wr) - CW'(w_rd);
  assign w_rd_ptr_next = w_rd ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  // A word written into an otherwise-empty FIFO is forwarded straight into the output register.
  assign w_head_data   = (w_wr && (r_count == CW'(w_rd))) ? outData : r_mem[w_rd_ptr_next];

  assign w_k_in_range  = (r_k < r_exp_count) && (r_k < KW'(NExpect));
  assign w_check_bad   = !w_k_in_range || (r_drain_data != r_expect[r_k[AW-1:0]]);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_wr || execFinished) w_state_next = S_RUN;
      S_RUN:   if (execFinished) w_state_next = S_FLUSH;
      S_FLUSH: if (r_count == '0) w_state_next = S_DONE;
      default: w_state_next = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= outData;
  end

  always_ff @(posedge clock) begin
    if (expectWe && (r_state == S_IDLE)) r_expect[expectAddr] <= expectData;
  end

  always_ff @(posedge clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_out_ready   <= 1'b0;
      r_drain_valid <= 1'b0;
      r_drain_data  <= '0;
      r_exp_count   <= '0;
      r_k           <= '0;
      r_mismatch    <= 1'b0;
      r_finished    <= 1'b0;
      r_success     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rd_ptr      <= w_rd_ptr_next;
      r_count       <= w_count_next;
      r_out_ready   <= ((w_state_next == S_IDLE) || (w_state_next == S_RUN)) &&
                       (w_count_next != CW'(NOut));
      r_drain_valid <= (w_count_next != '0);
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_count_next != '0) r_drain_data <= w_head_data;
      if (r_state == S_IDLE) r_exp_count <= expectCount;
      if (w_rd) begin
        if (w_check_bad) r_mismatch <= 1'b1;
        if (r_k != KW'(NExpect)) r_k <= r_k + 1'b1;
      end
      if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
        r_finished <= 1'b1;
        r_success  <= !r_mismatch && (r_k == r_exp_count);
      end
    end
  end

  assign outReady   = r_out_ready;
  assign drainValid = r_drain_valid;
  assign drainData  = r_drain_data;
  assign wordsOut   = r_count;
  assign finished   = r_finished;
  assign success    = r_success;

endmodule

// File: tb/tb_out_channel.sv
// tb/tb_out_channel.sv - Directed self-checking bench for out_channel (NOut=4, NExpect=16).
module tb_out_channel;

  localparam int W  = 12;
  localparam int NO = 4;
  localparam int NE = 16;

  logic          clock;
  logic          reset;
  logic          outValid;
  logic [W-1:0]  outData;
  logic          outReady;
  logic          execFinished;
  logic          drainValid;
  logic [W-1:0]  drainData;
  logic          drainReady;
  logic          expectWe;
  logic [3:0]    expectAddr;
  logic [W-1:0]  expectData;
  logic [4:0]    expectCount;
  logic [2:0]    wordsOut;
  logic          finished;
  logic          success;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  drained[$];
  logic [W-1:0]  exp_q[$];

  out_channel #(.MemoryElementWidth(W), .NOut(NO), .NExpect(NE)) dut (
    .clock        (clock),
    .reset        (reset),
    .outValid     (outValid),
    .outData      (outData),
    .outReady     (outReady),
    .execFinished (execFinished),
    .drainValid   (drainValid),
    .drainData    (drainData),
    .drainReady   (drainReady),
    .expectWe     (expectWe),
    .expectAddr   (expectAddr),
    .expectData   (expectData),
    .expectCount  (expectCount),
    .wordsOut     (wordsOut),
    .finished     (finished),
    .success      (success)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every drain transfer; the handshake is stable at the falling edge.
  always @(negedge clock) begin
    if (reset && drainValid && drainReady) drained.push_back(drainData);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    outValid     = 1'b0;
    execFinished = 1'b0;
    expectWe     = 1'b0;
    reset        = 1'b0;
    step();
    step();
    reset        = 1'b1;
    step();
    step();
    step();
    drained.delete();
  endtask

  task automatic load_expect(input logic [3:0] a, input logic [W-1:0] d);
    expectWe   = 1'b1;
    expectAddr = a;
    expectData = d;
    step();
    expectWe   = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    logic ok;
    ok       = 1'b0;
    outValid = 1'b1;
    outData  = d;
    for (int i = 0; i < 40; i++) begin
      if (outReady) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    outValid = 1'b0;
    check("write_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_finish(input string tag);
    execFinished = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (finished) break;
      step();
    end
    check({tag, "_finished"}, {31'd0, finished}, 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_len"}, drained.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < drained.size()) check($sformatf("%s_word%0d", tag, i), {20'd0, drained[i]}, {20'd0, exp_q[i]});
    end
  endtask

  task automatic pop_run(input string tag);
    expectCount = 5'd2;
    load_expect(4'd0, 12'd2);
    load_expect(4'd1, 12'd1);
    drainReady = 1'b1;
    write_word(12'd2);
    write_word(12'd1);
    run_finish(tag);
    check({tag, "_success"}, {31'd0, success}, 32'd1);
    exp_q = '{12'd2, 12'd1};
    check_drained(tag);
  endtask

  initial begin
    reset        = 1'b1;
    outValid     = 1'b0;
    outData      = '0;
    execFinished = 1'b0;
    drainReady   = 1'b0;
    expectWe     = 1'b0;
    expectAddr   = '0;
    expectData   = '0;
    expectCount  = '0;
    #1 reset = 1'b0;
    #22;
    check("rst_outReady",   {31'd0, outReady},   32'd0);
    check("rst_drainValid", {31'd0, drainValid}, 32'd0);
    check("rst_drainData",  {20'd0, drainData},  32'd0);
    check("rst_wordsOut",   {29'd0, wordsOut},   32'd0);
    check("rst_finished",   {31'd0, finished},   32'd0);
    check("rst_success",    {31'd0, success},    32'd0);
    step();
    reset = 1'b1;
    step();
    step();
    step();
    check("idle_outReady", {31'd0, outReady}, 32'd1);

    pop_run("pop");
    check("pop_done_outReady", {31'd0, outReady}, 32'd0);
    check("pop_done_drainValid", {31'd0, drainValid}, 32'd0);

    // Mismatch on the second word
    do_reset();
    expectCount = 5'd2;
    load_expect(4'd0, 12'd2);
    load_expect(4'd1, 12'd1);
    drainReady = 1'b1;
    write_word(12'd2);
    write_word(12'd3);
    run_finish("mism");
    check("mism_success", {31'd0, success}, 32'd0);

    // Backpressure fills the FIFO, then drains across the pointer wrap
    do_reset();
    expectCount = 5'd5;
    for (int i = 0; i < 5; i++) load_expect(4'(i), 12'(10 + i));
    drainReady = 1'b0;
    for (int i = 0; i < 4; i++) write_word(12'(10 + i));
    check("bp_outReady", {31'd0, outReady}, 32'd0);
    check("bp_wordsOut", {29'd0, wordsOut}, 32'd4);
    check("bp_drainValid", {31'd0, drainValid}, 32'd1);
    check("bp_drainData", {20'd0, drainData}, 32'd10);
    outValid = 1'b1;
    outData  = 12'd14;
    step();
    step();
    check("bp_not_taken", {29'd0, wordsOut}, 32'd4);
    check("bp_hold_data", {20'd0, drainData}, 32'd10);
    drainReady = 1'b1;
    write_word(12'd14);
    run_finish("bp");
    check("bp_success", {31'd0, success}, 32'd1);
    exp_q = '{12'd10, 12'd11, 12'd12, 12'd13, 12'd14};
    check_drained("bp");

    // Too many words for the expected count
    do_reset();
    expectCount = 5'd1;
    load_expect(4'd0, 12'd7);
    drainReady = 1'b1;
    write_word(12'd7);
    write_word(12'd7);
    run_finish("cnt_over");
    check("cnt_over_success", {31'd0, success}, 32'd0);

    // Too few words for the expected count
    do_reset();
    expectCount = 5'd3;
    load_expect(4'd0, 12'd7);
    load_expect(4'd1, 12'd8);
    load_expect(4'd2, 12'd9);
    drainReady = 1'b1;
    write_word(12'd7);
    write_word(12'd8);
    run_finish("cnt_under");
    check("cnt_under_success", {31'd0, success}, 32'd0);

    // Asynchronous reset between clock edges while words are buffered
    do_reset();
    expectCount = 5'd3;
    drainReady  = 1'b0;
    write_word(12'd1);
    write_word(12'd2);
    write_word(12'd3);
    check("mid_wordsOut_pre", {29'd0, wordsOut}, 32'd3);
    #1 reset = 1'b0;
    #1;
    check("mid_drainValid", {31'd0, drainValid}, 32'd0);
    check("mid_wordsOut",   {29'd0, wordsOut},   32'd0);
    check("mid_finished",   {31'd0, finished},   32'd0);
    check("mid_success",    {31'd0, success},    32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    step();
    drained.delete();
    pop_run("pop2");

    // Write and drain in the same cycle
    do_reset();
    expectCount = 5'd3;
    load_expect(4'd0, 12'd20);
    load_expect(4'd1, 12'd21);
    load_expect(4'd2, 12'd22);
    drainReady = 1'b0;
    write_word(12'd20);
    check("sim_wordsOut_pre", {29'd0, wordsOut}, 32'd1);
    drainReady = 1'b1;
    outValid   = 1'b1;
    outData    = 12'd21;
    step();
    outValid   = 1'b0;
    drainReady = 1'b0;
    check("sim_wordsOut", {29'd0, wordsOut}, 32'd1);
    check("sim_drainData", {20'd0, drainData}, 32'd21);
    drainReady = 1'b1;
    write_word(12'd22);
    run_finish("sim");
    check("sim_success", {31'd0, success}, 32'd1);
    exp_q = '{12'd20, 12'd21, 12'd22};
    check_drained("sim");

    // Empty run: execFinished straight from IDLE with nothing expected
    do_reset();
    expectCount = 5'd0;
    run_finish("empty");
    check("empty_success", {31'd0, success}, 32'd1);
    check("empty_wordsOut", {29'd0, wordsOut}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
